// File: rtl/ieee488_riot_bridge.sv
// Glue between the 6532 RIOT ports and the IEEE-488 open-collector bus.
// Optional bus monitor outputs (mon_byte, mon_count) enabled by IEEE_BUS_MONITOR_EN.
module ieee488_riot_bridge #(
    parameter int unsigned FILT    = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        ce,
    input  logic [7:0]  pa_out,
    output logic [7:0]  pa_in,
    input  logic [7:0]  pb_out,
    output logic [7:0]  pb_in,
    input  logic        bus_atn_i,
    input  logic        bus_dav_i,
    input  logic        bus_eoi_i,
    input  logic        bus_nrfd_i,
    input  logic        bus_ndac_i,
    input  logic [7:0]  bus_dio_i,
    output logic        bus_dav_o,
    output logic        bus_eoi_o,
    output logic        bus_nrfd_o,
    output logic        bus_ndac_o,
    output logic [7:0]  bus_dio_o,
    output logic        atn_irq_n
`ifdef IEEE_BUS_MONITOR_EN
    ,
    output logic [7:0]  mon_byte,
    output logic [15:0] mon_count
`endif
);

    localparam int unsigned NLINES    = 13;
    localparam logic [3:0]  FILT_LAST = 4'(FILT - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACKWAIT,
        ACKED,
        RELWAIT
    } state_t;

    // Line map: [7:0] DIO, [8] NDAC, [9] NRFD, [10] EOI, [11] DAV, [12] ATN
    logic [NLINES-1:0] raw_lines;
    logic [NLINES-1:0] sync1, sync2, filt;
    logic [3:0]        cnt [NLINES];

    logic        atn_f, dav_f, eoi_f, nrfd_f, ndac_f;
    logic [7:0]  dio_f;
    logic        atna;
    state_t      state, state_d;
    logic        force_ndac;
    logic [15:0] wd_cnt;
    logic        timeout;
    logic        unused_ok;

    assign raw_lines = {bus_atn_i, bus_dav_i, bus_eoi_i, bus_nrfd_i, bus_ndac_i, bus_dio_i};
    assign dio_f     = filt[7:0];
    assign ndac_f    = filt[8];
    assign nrfd_f    = filt[9];
    assign eoi_f     = filt[10];
    assign dav_f     = filt[11];
    assign atn_f     = filt[12];
    assign atna      = pb_out[0];
    assign unused_ok = &{1'b0, pb_out[7:6]};

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw_lines;
            sync2 <= sync1;
        end
    end

    // A line's filtered value only moves after FILT consecutive mismatching ce-cycles
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            filt <= '1;
            for (int unsigned i = 0; i < NLINES; i++) cnt[i] <= '0;
        end else if (ce) begin
            for (int unsigned i = 0; i < NLINES; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (cnt[i] == FILT_LAST) begin
                        filt[i] <= sync2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else if (ce) state <= state_d;
    end

    // ATN edges take priority; the destination is chosen with the current ATNA
    always_comb begin
        state_d    = state;
        force_ndac = 1'b0;
        atn_irq_n  = 1'b1;
        case (state)
            IDLE: begin
                if (!atn_f) state_d = atna ? ACKED : ACKWAIT;
            end
            ACKWAIT: begin
                force_ndac = 1'b1;
                atn_irq_n  = 1'b0;
                if (atn_f)     state_d = atna ? RELWAIT : IDLE;
                else if (atna) state_d = ACKED;
            end
            ACKED: begin
                if (atn_f) state_d = RELWAIT;
            end
            RELWAIT: begin
                force_ndac = 1'b1;
                if (!atn_f)     state_d = atna ? ACKED : ACKWAIT;
                else if (!atna) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (ce) begin
            if (pb_out[4]) begin
                wd_cnt  <= '0;
                timeout <= 1'b0;
            end else if (!ndac_f) begin
                if (wd_cnt != '1) wd_cnt <= wd_cnt + 16'd1;
                if (wd_cnt == TO_LAST) timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            bus_dav_o  <= 1'b1;
            bus_eoi_o  <= 1'b1;
            bus_nrfd_o <= 1'b1;
            bus_ndac_o <= 1'b1;
            bus_dio_o  <= '1;
            pa_in      <= '1;
            pb_in      <= 8'hBF;
        end else begin
            bus_dav_o  <= pb_out[4];
            bus_eoi_o  <= pb_out[3];
            bus_nrfd_o <= pb_out[1];
            bus_ndac_o <= pb_out[2] & ~force_ndac;
            bus_dio_o  <= (pb_out[5] & atn_f) ? pa_out : 8'hFF;
            pa_in      <= dio_f;
            pb_in      <= {atn_f, timeout, 1'b1, dav_f, eoi_f, ndac_f, nrfd_f, 1'b1};
        end
    end

`ifdef IEEE_BUS_MONITOR_EN
    logic dav_prev;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            dav_prev  <= 1'b1;
            mon_byte  <= '0;
            mon_count <= '0;
        end else begin
            dav_prev <= dav_f;
            if (dav_prev && !dav_f) begin
                mon_byte  <= dio_f;
                mon_count <= mon_count + 16'd1;
            end
        end
    end
`endif

endmodule
